// File: rtl/cache_control_if.sv
// Handshake bundle between the cache sequencer, the CPU port, the cache
// datapath and physical memory.
interface cache_control_if;
   logic mem_read;
   logic mem_write;
   logic mem_resp;
   logic hit;
   logic evict;
   logic load_tag;
   logic load_d;
   logic pmem_read;
   logic pmem_write;
   logic pmem_resp;

   // master: the CPU/datapath/memory side that surrounds the controller
   modport master (
      output mem_read, mem_write, hit, evict, pmem_resp,
      input  mem_resp, load_tag, load_d, pmem_read, pmem_write
   );

   modport slave (
      input  mem_read, mem_write, hit, evict, pmem_resp,
      output mem_resp, load_tag, load_d, pmem_read, pmem_write
   );
endinterface

// File: rtl/cache_control.sv
// Sequencer for the 2-way set-associative cache: hit service, dirty
// writeback, line refill, plus saturating hit/miss/writeback counters.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for a request; hits are answered in the same cycle
// S_WRITEBACK | writing the dirty LRU victim to pmem until pmem_resp
// S_ALLOCATE  | reading the missing line from pmem until pmem_resp
module cache_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cache_control_if.slave       bus,
   input  logic                 perf_clr,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   refill;
   logic   req;
   logic   mem_resp_c, load_tag_c, load_d_c, pmem_read_c, pmem_write_c;
   logic   set_refill, clr_refill;
   logic   miss_evt, wb_evt, hit_evt;

   assign req = bus.mem_read | bus.mem_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      mem_resp_c   = 1'b0;
      load_tag_c   = 1'b0;
      load_d_c     = 1'b0;
      pmem_read_c  = 1'b0;
      pmem_write_c = 1'b0;
      set_refill   = 1'b0;
      clr_refill   = 1'b0;
      miss_evt     = 1'b0;
      wb_evt       = 1'b0;
      case (state)
         S_IDLE: begin
            // the refill marker only lives for the first IDLE cycle after a fill
            clr_refill = 1'b1;
            if (req) begin
               if (bus.hit) begin
                  mem_resp_c = 1'b1;
                  load_d_c   = bus.mem_write;
               end else begin
                  miss_evt  = 1'b1;
                  state_nxt = bus.evict ? S_WRITEBACK : S_ALLOCATE;
               end
            end
         end
         S_WRITEBACK: begin
            pmem_write_c = 1'b1;
            if (bus.pmem_resp) begin
               wb_evt    = 1'b1;
               state_nxt = S_ALLOCATE;
            end
         end
         S_ALLOCATE: begin
            pmem_read_c = 1'b1;
            if (bus.pmem_resp) begin
               load_d_c   = 1'b1;
               load_tag_c = 1'b1;
               set_refill = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Strobes are forced low while reset is held, even with a hit on the inputs.
   assign bus.mem_resp   = rst_n & mem_resp_c;
   assign bus.load_tag   = rst_n & load_tag_c;
   assign bus.load_d     = rst_n & load_d_c;
   assign bus.pmem_read  = rst_n & pmem_read_c;
   assign bus.pmem_write = rst_n & pmem_write_c;
   assign busy           = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refill <= 1'b0;
      end else if (set_refill) begin
         refill <= 1'b1;
      end else if (clr_refill) begin
         refill <= 1'b0;
      end
   end

   // The response right after a refill belongs to the miss already counted.
   assign hit_evt = mem_resp_c & ~refill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else if (perf_clr) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (hit_evt && (hit_count != '1)) begin
            hit_count <= hit_count + 1'b1;
         end
         if (miss_evt && (miss_count != '1)) begin
            miss_count <= miss_count + 1'b1;
         end
         if (wb_evt && (wb_count != '1)) begin
            wb_count <= wb_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: miss/hit/writeback sequencing, async
// reset mid-transaction, abandoned request and counter saturation/clear.
module tb_cache_control;
   logic        clk;
   logic        rst_n;
   logic        perf_clr;
   logic [15:0] hit_count, miss_count, wb_count;
   logic        busy;
   int          checks;
   int          errors;

   cache_control_if bus ();

   cache_control #(.CNT_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .perf_clr  (perf_clr),
      .hit_count (hit_count),
      .miss_count(miss_count),
      .wb_count  (wb_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.hit       = 1'b0;
      bus.evict     = 1'b0;
      bus.pmem_resp = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      perf_clr = 1'b0;
      idle_inputs();
      bus.mem_read = 1'b1;
      bus.hit      = 1'b1;
      #12;
      checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL rst_mem_resp actual=%b expected=0", bus.mem_resp); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy actual=%b expected=0", busy); end
      checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0 || wb_count !== 16'h0) begin errors++; $display("FAIL rst_counters actual=%h/%h/%h expected=0/0/0", hit_count, miss_count, wb_count); end
      idle_inputs();
      smp();
      rst_n = 1'b1;
   endtask

   task automatic test_cold_miss();
      cyc();
      bus.mem_read = 1'b1; bus.hit = 1'b0; bus.evict = 1'b0;
      smp();
      checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL miss_idle_decode actual=%b%b expected=00", bus.mem_resp, bus.pmem_read); end
      for (int i = 0; i < 5; i++) begin
         cyc();
         bus.pmem_resp = (i == 4);
         smp();
         checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL alloc_pmem_read cyc=%0d actual=%b%b%b expected=101", i, bus.pmem_read, bus.pmem_write, busy); end
         checks++; if (bus.load_d !== (i == 4) || bus.load_tag !== (i == 4) || bus.mem_resp !== 1'b0) begin errors++; $display("FAIL alloc_load cyc=%0d actual=%b%b%b expected=%b%b0", i, bus.load_d, bus.load_tag, bus.mem_resp, (i == 4), (i == 4)); end
         if (i == 0) begin
            checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL miss_count_inc actual=%0d expected=1", miss_count); end
         end
      end
      cyc();
      bus.pmem_resp = 1'b0; bus.hit = 1'b1;
      smp();
      checks++; if (bus.mem_resp !== 1'b1 || bus.load_d !== 1'b0 || bus.load_tag !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL refill_resp actual=%b%b%b%b expected=1000", bus.mem_resp, bus.load_d, bus.load_tag, busy); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (hit_count !== 16'd0 || miss_count !== 16'd1 || wb_count !== 16'd0) begin errors++; $display("FAIL cold_counters actual=%0d/%0d/%0d expected=0/1/0", hit_count, miss_count, wb_count); end
   endtask

   task automatic test_read_hit();
      cyc();
      bus.mem_read = 1'b1; bus.hit = 1'b1;
      smp();
      checks++; if (bus.mem_resp !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_hit actual=%b%b%b%b expected=1000", bus.mem_resp, bus.pmem_read, bus.pmem_write, busy); end
      checks++; if (bus.load_d !== 1'b0) begin errors++; $display("FAIL read_hit_load_d actual=%b expected=0", bus.load_d); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL read_hit_count actual=%0d expected=1", hit_count); end
   endtask

   task automatic test_write_hit();
      cyc();
      bus.mem_write = 1'b1; bus.hit = 1'b1;
      smp();
      checks++; if (bus.mem_resp !== 1'b1 || bus.load_d !== 1'b1 || bus.load_tag !== 1'b0) begin errors++; $display("FAIL write_hit actual=%b%b%b expected=110", bus.mem_resp, bus.load_d, bus.load_tag); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL write_hit_count actual=%0d expected=2", hit_count); end
   endtask

   task automatic test_writeback();
      // fill the second way (tag 0x25) with a clean miss
      cyc();
      bus.mem_read = 1'b1; bus.hit = 1'b0; bus.evict = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         bus.pmem_resp = (i == 1);
      end
      cyc();
      bus.pmem_resp = 1'b0; bus.hit = 1'b1;
      smp();
      checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL fill2_resp actual=%b expected=1", bus.mem_resp); end
      cyc();
      idle_inputs();
      // tag 0x26 with a dirty LRU victim
      bus.mem_read = 1'b1; bus.evict = 1'b1;
      smp();
      checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_write !== 1'b0) begin errors++; $display("FAIL evict_idle actual=%b%b expected=00", bus.mem_resp, bus.pmem_write); end
      for (int i = 0; i < 3; i++) begin
         cyc();
         bus.pmem_resp = (i == 2);
         smp();
         checks++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.load_d !== 1'b0 || bus.load_tag !== 1'b0) begin errors++; $display("FAIL wb_phase cyc=%0d actual=%b%b%b%b expected=1000", i, bus.pmem_write, bus.pmem_read, bus.load_d, bus.load_tag); end
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         bus.pmem_resp = (i == 1);
         smp();
         checks++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b1) begin errors++; $display("FAIL wb_alloc_phase cyc=%0d actual=%b%b expected=01", i, bus.pmem_write, bus.pmem_read); end
         if (i == 0) begin
            checks++; if (wb_count !== 16'd1) begin errors++; $display("FAIL wb_count actual=%0d expected=1", wb_count); end
         end
      end
      cyc();
      bus.pmem_resp = 1'b0; bus.evict = 1'b0; bus.hit = 1'b1;
      smp();
      checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL wb_resp actual=%b expected=1", bus.mem_resp); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (hit_count !== 16'd2 || miss_count !== 16'd3 || wb_count !== 16'd1) begin errors++; $display("FAIL wb_counters actual=%0d/%0d/%0d expected=2/3/1", hit_count, miss_count, wb_count); end
   endtask

   task automatic test_reset_mid_alloc();
      cyc();
      bus.mem_read = 1'b1;
      cyc();
      cyc();
      smp();
      checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL pre_reset_alloc actual=%b expected=1", bus.pmem_read); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.pmem_read !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_drop actual=%b%b expected=00", bus.pmem_read, busy); end
      checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0 || wb_count !== 16'h0) begin errors++; $display("FAIL async_reset_counters actual=%h/%h/%h expected=0/0/0", hit_count, miss_count, wb_count); end
      idle_inputs();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         smp();
         checks++; if (bus.load_tag !== 1'b0 || bus.load_d !== 1'b0 || busy !== 1'b0 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL post_reset_idle cyc=%0d actual=%b%b%b%b expected=0000", i, bus.load_tag, bus.load_d, busy, bus.pmem_read); end
         cyc();
      end
   endtask

   task automatic test_abandon();
      bus.mem_read = 1'b1;
      cyc();
      bus.mem_read = 1'b0;
      cyc();
      bus.pmem_resp = 1'b1;
      smp();
      checks++; if (bus.pmem_read !== 1'b1 || bus.load_tag !== 1'b1) begin errors++; $display("FAIL abandon_completes actual=%b%b expected=11", bus.pmem_read, bus.load_tag); end
      cyc();
      bus.pmem_resp = 1'b0; bus.hit = 1'b1;
      smp();
      checks++; if (bus.mem_resp !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abandon_no_resp actual=%b%b expected=00", bus.mem_resp, busy); end
      cyc();
      bus.mem_read = 1'b1;
      cyc();
      idle_inputs();
      smp();
      checks++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin errors++; $display("FAIL abandon_counters actual=%0d/%0d expected=1/1", hit_count, miss_count); end
   endtask

   task automatic test_saturation();
      cyc();
      bus.mem_read = 1'b1; bus.hit = 1'b1;
      repeat (65534) cyc();
      smp();
      checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL hit_saturate actual=%h expected=ffff", hit_count); end
      cyc();
      smp();
      checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL hit_no_wrap actual=%h expected=ffff", hit_count); end
      cyc();
      perf_clr = 1'b1;
      cyc();
      perf_clr = 1'b0;
      smp();
      checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL perf_clr_priority actual=%h/%h expected=0/0", hit_count, miss_count); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL post_clr_count actual=%0d expected=1", hit_count); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_cold_miss();
      test_read_hit();
      test_write_hit();
      test_writeback();
      test_reset_mid_alloc();
      test_abandon();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
